fc_layer_sched: RTL and testbench

- Sequencer for the 12-lane fully-connected dot-product unit. Each output neuron's dot product is split into chunks of DEPTH_IN elements.
- For every output neuron, the block:
  - issues feature-buffer and weight-buffer read addresses chunk by chunk;
  - tracks the fixed read-plus-MAC pipeline latency;
  - accumulates the returned chunk partial sums onto a bias;
  - presents one result per neuron on a valid/ready output.
- Sits between the layer-level control FSM, the feature/weight/bias buffers and the dot-product unit.

---
 rtl/fc_layer_sched.sv | 155 +++++++++++++++
 tb/tb_fc_layer_sched.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sched.sv
// Chunked dot-product sequencer: issues feature/weight reads per output neuron,
// accumulates returned partial sums onto the neuron bias and hands out one result per neuron.
module fc_layer_sched #(
  parameter int PSUM_W   = 24,
  parameter int ACC_W    = 32,
  parameter int BIAS_W   = 16,
  parameter int CNT_W    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cfg_num_out,
  input  logic [CNT_W-1:0]     cfg_num_chunk,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [CNT_W-1:0]     feat_addr,
  output logic [2*CNT_W-1:0]   wgt_addr,
  output logic [CNT_W-1:0]     bias_addr,
  input  logic [BIAS_W-1:0]    bias_in,
  input  logic [PSUM_W-1:0]    psum_in,
  output logic [ACC_W-1:0]     out_data,
  output logic [CNT_W-1:0]     out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           state_dbg
);

  localparam int WA_W = 2 * CNT_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    num_out_q;
  logic [CNT_W-1:0]    num_chunk_q;
  logic [WA_W-1:0]     wgt_base;
  logic [PIPE_LAT-1:0] pipe_v;
  logic [PIPE_LAT-1:0] pipe_first;
  logic [PIPE_LAT-1:0] pipe_last;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [ACC_W-1:0]    psum_ext;
  logic [ACC_W-1:0]    bias_ext;
  logic                last_chunk;
  logic                last_neuron;

  // feat_addr doubles as the chunk counter and bias_addr as the neuron counter.
  assign last_chunk  = (feat_addr == num_chunk_q - CNT_W'(1));
  assign last_neuron = (bias_addr == num_out_q - CNT_W'(1));
  assign state_dbg   = state;

  always_comb begin
    psum_ext = {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
    bias_ext = {{(ACC_W-BIAS_W){bias_in[BIAS_W-1]}}, bias_in};
    if (pipe_first[PIPE_LAT-1]) acc_next = bias_ext + psum_ext;
    else                        acc_next = acc + psum_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      num_out_q   <= '0;
      num_chunk_q <= '0;
      wgt_base    <= '0;
      pipe_v      <= '0;
      pipe_first  <= '0;
      pipe_last   <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      feat_addr   <= '0;
      wgt_addr    <= '0;
      bias_addr   <= '0;
      out_data    <= '0;
      out_idx     <= '0;
      out_valid   <= 1'b0;
    end else begin
      // Stage 0 tags the read issued this cycle; the top stage lines up with psum_in.
      pipe_v[0]     <= rd_en;
      pipe_first[0] <= rd_en && (feat_addr == '0);
      pipe_last[0]  <= rd_en && last_chunk;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_v[i]     <= pipe_v[i-1];
        pipe_first[i] <= pipe_first[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
      if (pipe_v[PIPE_LAT-1]) acc <= acc_next;

      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            num_out_q   <= cfg_num_out;
            num_chunk_q <= cfg_num_chunk;
            wgt_base    <= '0;
            bias_addr   <= '0;
            feat_addr   <= '0;
            wgt_addr    <= '0;
            rd_en       <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (last_chunk) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            feat_addr <= feat_addr + CNT_W'(1);
            wgt_addr  <= wgt_addr + WA_W'(1);
          end
        end
        S_DRAIN: begin
          // Result is registered from the final sum so out_valid rises one cycle after the last psum.
          if (pipe_v[PIPE_LAT-1] && pipe_last[PIPE_LAT-1]) begin
            out_data  <= acc_next;
            out_idx   <= bias_addr;
            out_valid <= 1'b1;
            state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (last_neuron) begin
              state <= S_DONE;
            end else begin
              bias_addr <= bias_addr + CNT_W'(1);
              wgt_base  <= wgt_base + {{CNT_W{1'b0}}, num_chunk_q};
              wgt_addr  <= wgt_base + {{CNT_W{1'b0}}, num_chunk_q};
              feat_addr <= '0;
              rd_en     <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sched.sv
// Directed bench for fc_layer_sched with a two-cycle read+MAC model and per-scenario checks.
module tb_fc_layer_sched;

  localparam int PSUM_W = 24;
  localparam int ACC_W  = 32;
  localparam int BIAS_W = 16;
  localparam int CNT_W  = 10;
  localparam int WA_W   = 2 * CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  cfg_num_out = '0;
  logic [CNT_W-1:0]  cfg_num_chunk = '0;
  logic              busy, done, rd_en, out_valid;
  logic [CNT_W-1:0]  feat_addr, bias_addr, out_idx;
  logic [WA_W-1:0]   wgt_addr;
  logic [BIAS_W-1:0] bias_in;
  logic [PSUM_W-1:0] psum_in;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready = 1'b0;
  logic [2:0]        state_dbg;

  int errors = 0;
  int checks = 0;

  // Buffer / dot-product unit model: psum is a function of the addresses read two cycles earlier.
  int psum_mode = 0, bias_mode = 0, psum_const = 0, bias_const = 0;
  int p_val, b_val;
  logic             d1_v = 1'b0, d2_v = 1'b0;
  logic [CNT_W-1:0] d1_f = '0, d2_f = '0;
  logic [WA_W-1:0]  d1_w = '0, d2_w = '0;

  logic [WA_W-1:0]  exp_wgt_q[$];
  logic [CNT_W-1:0] exp_feat_q[$];
  logic [CNT_W-1:0] exp_neu_q[$];
  logic [ACC_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_idx_q[$];

  fc_layer_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_out(cfg_num_out), .cfg_num_chunk(cfg_num_chunk),
    .busy(busy), .done(done), .rd_en(rd_en),
    .feat_addr(feat_addr), .wgt_addr(wgt_addr), .bias_addr(bias_addr),
    .bias_in(bias_in), .psum_in(psum_in),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1_v <= rd_en;  d1_f <= feat_addr;  d1_w <= wgt_addr;
    d2_v <= d1_v;   d2_f <= d1_f;       d2_w <= d1_w;
  end

  always_comb begin
    p_val = 32'h005A5A5A;
    if (d2_v) begin
      case (psum_mode)
        0:       p_val = psum_const;
        1:       p_val = int'(d2_f) + 1;
        default: p_val = int'(d2_w) * 3 - 7;
      endcase
    end
    psum_in = p_val[PSUM_W-1:0];
    if (bias_mode == 0) b_val = bias_const;
    else                b_val = int'(bias_addr) * 100 - 50;
    bias_in = b_val[BIAS_W-1:0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int nout, input int nc);
    cfg_num_out   = CNT_W'(nout);
    cfg_num_chunk = CNT_W'(nc);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({busy, done, rd_en, feat_addr, wgt_addr, bias_addr, out_data, out_idx, out_valid, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b out_valid=%b out_data=%h state=%0d, expected all 0",
               busy, done, rd_en, out_valid, out_data, state_dbg);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({busy, rd_en, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle_hold: got busy=%b rd_en=%b out_valid=%b, expected 000", busy, rd_en, out_valid);
    end
  endtask

  task automatic test_single();
    psum_mode = 0; psum_const = 100; bias_mode = 0; bias_const = 5; out_ready = 1'b1;
    do_start(1, 1);
    checks++;
    if ({rd_en, busy, feat_addr, wgt_addr} !== {1'b1, 1'b1, 10'd0, 20'd0}) begin
      errors++;
      $display("FAIL single_issue: got rd_en=%b busy=%b feat=%0d wgt=%0d, expected 1 1 0 0", rd_en, busy, feat_addr, wgt_addr);
    end
    step();
    checks++;
    if (rd_en !== 1'b0) begin
      errors++;
      $display("FAIL single_rd_one_cycle: got rd_en=%b, expected 0", rd_en);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got out_valid=%b, expected 0", out_valid);
    end
    step();
    checks++;
    if ({out_valid, out_data, out_idx} !== {1'b1, 32'd105, 10'd0}) begin
      errors++;
      $display("FAIL single_result: got valid=%b data=%0d idx=%0d, expected 1 105 0", out_valid, out_data, out_idx);
    end
    step();
    checks++;
    if ({out_valid, done, busy} !== 3'b001) begin
      errors++;
      $display("FAIL single_after_accept: got valid=%b done=%b busy=%b, expected 0 0 1", out_valid, done, busy);
    end
    step();
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL single_done: got done=%b busy=%b, expected 1 0", done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_multi();
    int cyc;
    logic [WA_W-1:0] ew; logic [CNT_W-1:0] ef, en; logic [ACC_W-1:0] ed; logic [CNT_W-1:0] ei;
    psum_mode = 1; bias_mode = 0; bias_const = -10; out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 4; c++) begin
        exp_wgt_q.push_back(WA_W'(n * 4 + c));
        exp_feat_q.push_back(CNT_W'(c));
        exp_neu_q.push_back(CNT_W'(n));
      end
      exp_q.push_back(32'd0);
      exp_idx_q.push_back(CNT_W'(n));
    end
    do_start(3, 4);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (rd_en) begin
        checks++;
        if (exp_wgt_q.size() == 0) begin
          errors++;
          $display("FAIL multi_extra_issue: got wgt=%0d, expected no read", wgt_addr);
        end else begin
          ew = exp_wgt_q.pop_front(); ef = exp_feat_q.pop_front(); en = exp_neu_q.pop_front();
          if ({wgt_addr, feat_addr, bias_addr} !== {ew, ef, en}) begin
            errors++;
            $display("FAIL multi_addr: got wgt=%0d feat=%0d bias=%0d, expected %0d %0d %0d", wgt_addr, feat_addr, bias_addr, ew, ef, en);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL multi_extra_result: got data=%0d, expected none", out_data);
        end else begin
          ed = exp_q.pop_front(); ei = exp_idx_q.pop_front();
          if ({out_data, out_idx} !== {ed, ei}) begin
            errors++;
            $display("FAIL multi_result: got data=%0d idx=%0d, expected %0d %0d", $signed(out_data), out_idx, ed, ei);
          end
        end
      end
      step(); cyc++;
    end
    checks++;
    if (done !== 1'b1 || exp_wgt_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL multi_complete: got done=%b reads_left=%0d results_left=%0d, expected 1 0 0", done, exp_wgt_q.size(), exp_q.size());
    end
    exp_wgt_q.delete(); exp_feat_q.delete(); exp_neu_q.delete(); exp_q.delete(); exp_idx_q.delete();
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    psum_mode = 0; psum_const = 10; bias_mode = 0; bias_const = 1; out_ready = 1'b0;
    do_start(2, 2);
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_wait_valid: got out_valid=%b, expected 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, out_data, out_idx, rd_en} !== {1'b1, 32'd21, 10'd0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b data=%0d idx=%0d rd_en=%b, expected 1 21 0 0", out_valid, out_data, out_idx, rd_en);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({rd_en, out_valid, feat_addr, wgt_addr, bias_addr} !== {1'b1, 1'b0, 10'd0, 20'd2, 10'd1}) begin
      errors++;
      $display("FAIL bp_next_issue: got rd_en=%b valid=%b feat=%0d wgt=%0d bias=%0d, expected 1 0 0 2 1",
               rd_en, out_valid, feat_addr, wgt_addr, bias_addr);
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    checks++;
    if ({out_valid, out_data, out_idx} !== {1'b1, 32'd21, 10'd1}) begin
      errors++;
      $display("FAIL bp_second: got valid=%b data=%0d idx=%0d, expected 1 21 1", out_valid, out_data, out_idx);
    end
    out_ready = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin step(); cyc++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: got done=%b, expected 1", done);
    end
    step();
  endtask

  task automatic test_wrap();
    int cyc;
    logic [ACC_W-1:0] model;
    psum_mode = 0; psum_const = 32'h007FFFFF; bias_mode = 0; bias_const = 32'h00007FFF; out_ready = 1'b1;
    model = 32'h00007FFF;
    for (int i = 0; i < 512; i++) model = model + 32'h007FFFFF;
    do_start(1, 512);
    cyc = 0;
    while (!out_valid && cyc < 600) begin step(); cyc++; end
    checks++;
    if ({out_valid, out_data, out_idx} !== {1'b1, model, 10'd0}) begin
      errors++;
      $display("FAIL wrap_result: got valid=%b data=%h idx=%0d, expected 1 %h 0", out_valid, out_data, out_idx, model);
    end
    cyc = 0;
    while (!done && cyc < 20) begin step(); cyc++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: got done=%b, expected 1", done);
    end
    step();
  endtask

  task automatic test_start_busy();
    int cyc;
    logic [WA_W-1:0] ew; logic [CNT_W-1:0] ef, en; logic [ACC_W-1:0] ed; logic [CNT_W-1:0] ei;
    psum_mode = 2; bias_mode = 1; out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 3; c++) begin
        exp_wgt_q.push_back(WA_W'(n * 3 + c));
        exp_feat_q.push_back(CNT_W'(c));
        exp_neu_q.push_back(CNT_W'(n));
      end
    end
    exp_q.push_back(32'hFFFFFFC2); exp_idx_q.push_back(10'd0);
    exp_q.push_back(32'd65);       exp_idx_q.push_back(10'd1);
    do_start(2, 3);
    cfg_num_out = 10'd5; cfg_num_chunk = 10'd1;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (rd_en) begin
        checks++;
        if (exp_wgt_q.size() == 0) begin
          errors++;
          $display("FAIL busy_extra_issue: got wgt=%0d, expected no read", wgt_addr);
        end else begin
          ew = exp_wgt_q.pop_front(); ef = exp_feat_q.pop_front(); en = exp_neu_q.pop_front();
          if ({wgt_addr, feat_addr, bias_addr} !== {ew, ef, en}) begin
            errors++;
            $display("FAIL busy_addr: got wgt=%0d feat=%0d bias=%0d, expected %0d %0d %0d", wgt_addr, feat_addr, bias_addr, ew, ef, en);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL busy_extra_result: got data=%0d, expected none", out_data);
        end else begin
          ed = exp_q.pop_front(); ei = exp_idx_q.pop_front();
          if ({out_data, out_idx} !== {ed, ei}) begin
            errors++;
            $display("FAIL busy_result: got data=%h idx=%0d, expected %h %0d", out_data, out_idx, ed, ei);
          end
        end
      end
      start = (cyc % 3 == 1);
      step(); cyc++;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || exp_wgt_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_complete: got done=%b reads_left=%0d results_left=%0d, expected 1 0 0", done, exp_wgt_q.size(), exp_q.size());
    end
    step(); step();
    checks++;
    if ({busy, rd_en} !== 2'b00) begin
      errors++;
      $display("FAIL busy_no_restart: got busy=%b rd_en=%b, expected 0 0", busy, rd_en);
    end
    exp_wgt_q.delete(); exp_feat_q.delete(); exp_neu_q.delete(); exp_q.delete(); exp_idx_q.delete();
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic seen;
    psum_mode = 1; bias_mode = 0; bias_const = -10; out_ready = 1'b1;
    do_start(3, 4);
    cyc = 0;
    while (!(rd_en && bias_addr == 10'd1) && cyc < 50) begin step(); cyc++; end
    checks++;
    if ({rd_en, bias_addr} !== {1'b1, 10'd1}) begin
      errors++;
      $display("FAIL rstmid_reach_n1: got rd_en=%b bias=%0d, expected 1 1", rd_en, bias_addr);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({busy, done, rd_en, feat_addr, wgt_addr, bias_addr, out_data, out_idx, out_valid, state_dbg} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got busy=%b rd_en=%b wgt=%0d bias=%0d valid=%b state=%0d, expected all 0",
               busy, rd_en, wgt_addr, bias_addr, out_valid, state_dbg);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | out_valid | rd_en | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: got activity=%b, expected 0", seen);
    end
    psum_mode = 0; psum_const = 100; bias_const = 5;
    do_start(1, 2);
    checks++;
    if ({rd_en, wgt_addr, feat_addr, bias_addr} !== {1'b1, 20'd0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL rstmid_restart: got rd_en=%b wgt=%0d feat=%0d bias=%0d, expected 1 0 0 0", rd_en, wgt_addr, feat_addr, bias_addr);
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    checks++;
    if ({out_valid, out_data, out_idx} !== {1'b1, 32'd205, 10'd0}) begin
      errors++;
      $display("FAIL rstmid_result: got valid=%b data=%0d idx=%0d, expected 1 205 0", out_valid, out_data, out_idx);
    end
    cyc = 0;
    while (!done && cyc < 20) begin step(); cyc++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_done: got done=%b, expected 1", done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
